live_edge_conditioner: RTL and testbench
========================================

Name: live_edge_conditioner

Overview:
- Conditions the asynchronous LIVE (spill gate) input of the trigger CDT for the downstream capture stages.
- Synchronises the input, rejects glitches shorter than MIN_WIDTH clock cycles, and emits single-cycle live_rising/live_falling pulses.
- live_rising drives the clear input of every signal_capture instance.
- Also keeps a spill counter and measures the duration of each live window.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on live_in (allowed range 2..4)
MIN_WIDTH, 4, consecutive synchronised cycles required to accept a level change (allowed range 1..255)
CNT_W, 16, width of spill_count
DUR_W, 32, width of live_duration

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
live_in  input  1  asynchronous LIVE gate from NIM/LVDS receiver
live_level  output  1  filtered, synchronised LIVE level
live_rising  output  1  one-cycle pulse on accepted 0->1 transition
live_falling  output  1  one-cycle pulse on accepted 1->0 transition
spill_count  output  CNT_W  number of accepted rising transitions, wraps modulo 2^CNT_W
live_duration  output  DUR_W  cycles live_level was 1 in the last completed window
duration_valid  output  1  one-cycle pulse when live_duration is updated
duration_ovf  output  1  the last completed window saturated the duration counter

Behaviour:
- Reset: all outputs 0; synchroniser flops 0; filter counter 0; FSM to IDLE. Reset is sampled only on posedge clk.
- Synchroniser: a chain of SYNC_STAGES flops. The last flop is sync_q. No other logic reads live_in.
- FSM states and transitions:
  - IDLE (level 0): sync_q=1 -> ARM_ON, filter count=1.
  - ARM_ON: sync_q=1 and count==MIN_WIDTH -> LIVE. sync_q=1 and count<MIN_WIDTH -> count+1. sync_q=0 -> IDLE, count=0.
  - LIVE (level 1): sync_q=0 -> ARM_OFF, count=1.
  - ARM_OFF: symmetric to ARM_ON. Accepted -> IDLE. Rejected -> LIVE.
  - For MIN_WIDTH=1, the first sample that differs is accepted immediately. The ARM state is left on the same cycle it is entered in effect.
- live_level: 1 in LIVE and ARM_OFF, else 0.
- live_rising: high for exactly the one cycle in which live_level first becomes 1. It is registered, coincident with the live_level transition.
- live_falling: same rule for the 1->0 transition.
- Latency: for a clean input edge, the pulse is high in the cycle after the (SYNC_STAGES+MIN_WIDTH)th posedge that samples the new level. Default is 6 cycles. Both edges have equal latency.
- Glitch rule:
  - An input level held for fewer than MIN_WIDTH synchronised cycles produces no pulse and no level change.
  - Exactly MIN_WIDTH cycles is accepted.
- spill_count: +1 on the live_rising cycle; wraps from all-ones to 0.
- Duration counter:
  - Loads 1 on the live_rising cycle.
  - Increments each following cycle while live_level=1.
  - Saturates at 2^DUR_W-1 and sets an internal ovf flag.
  - A clean input window of N>=MIN_WIDTH cycles yields live_duration=N. Rejected dropouts inside the window are counted.
- On the live_falling cycle:
  - live_duration latches the counter value.
  - duration_ovf latches the ovf flag.
  - duration_valid pulses high for 1 cycle.
  - live_duration and duration_ovf hold their values until the next falling edge or reset.
- Reset mid-window: everything returns to reset values with no live_falling and no duration_valid.
  - If live_in is still high after reset releases, this is treated as a new spill: live_rising fires after the normal latency and spill_count becomes 1.
- live_rising and live_falling never assert in the same cycle. The minimum spacing between them is MIN_WIDTH cycles.

Test Plan:
- Defaults, live_in high for 100 cycles, then low -> live_rising at latency 6 (one pulse), live_level high for 100 cycles, one live_falling, live_duration=100, duration_valid one pulse, spill_count=1, duration_ovf=0.
- live_in high for 3 cycles, then low for 20 -> no pulses, live_level stays 0, spill_count=0. Repeat with 4 cycles high -> rising, and falling 4 cycles later, live_duration=4.
- Live window of 200 cycles with a 2-cycle low dropout at cycle 50 -> no live_falling until the end, live_duration=200, spill_count=1.
- DUR_W=8, live window of 300 cycles -> live_duration=255, duration_ovf=1. Next window of 10 cycles -> live_duration=10, duration_ovf=0.
- CNT_W=4, 17 clean windows of 20 cycles each with 20-cycle gaps -> spill_count=1 after the 17th rising edge.
- reset pulsed 1 cycle at cycle 30 of a live window, live_in kept high -> all outputs 0, no live_falling or duration_valid. live_rising 6 cycles after reset deasserts, spill_count=1.

Source files
------------

// File: rtl/live_edge_conditioner.sv
// rtl/live_edge_conditioner.sv - LIVE gate synchroniser, glitch filter, edge pulses, spill counter and window timer
// live_rising is intended to clear every signal_capture instance at spill start.
module live_edge_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 4,
  parameter int CNT_W       = 16,
  parameter int DUR_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             live_in,
  output logic             live_level,
  output logic             live_rising,
  output logic             live_falling,
  output logic [CNT_W-1:0] spill_count,
  output logic [DUR_W-1:0] live_duration,
  output logic             duration_valid,
  output logic             duration_ovf
);

  localparam int FW = 8;
  // Count value at which the current sample is the MIN_WIDTH-th agreeing one.
  localparam logic [FW-1:0] LAST_CNT  = FW'(MIN_WIDTH - 1);
  localparam bit            IMMEDIATE = (MIN_WIDTH == 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM_ON,
    LIVE,
    ARM_OFF
  } state_t;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  state_t                 state;
  logic [FW-1:0]          filt_cnt;
  logic [DUR_W-1:0]       dur_cnt;
  logic                   dur_ovf;
  logic                   rise_now;
  logic                   fall_now;

  assign sync_q = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], live_in};
    end
  end

  // Accepted transitions, decided from the current state and synchronised sample.
  always_comb begin
    rise_now = 1'b0;
    fall_now = 1'b0;
    case (state)
      IDLE:    rise_now = sync_q && IMMEDIATE;
      ARM_ON:  rise_now = sync_q && (filt_cnt >= LAST_CNT);
      LIVE:    fall_now = !sync_q && IMMEDIATE;
      ARM_OFF: fall_now = !sync_q && (filt_cnt >= LAST_CNT);
      default: begin
        rise_now = 1'b0;
        fall_now = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      filt_cnt       <= '0;
      live_level     <= 1'b0;
      live_rising    <= 1'b0;
      live_falling   <= 1'b0;
      duration_valid <= 1'b0;
      spill_count    <= '0;
      dur_cnt        <= '0;
      dur_ovf        <= 1'b0;
      live_duration  <= '0;
      duration_ovf   <= 1'b0;
    end else begin
      live_rising    <= rise_now;
      live_falling   <= fall_now;
      duration_valid <= fall_now;

      case (state)
        IDLE: begin
          if (sync_q) begin
            if (IMMEDIATE) begin
              state <= LIVE;
            end else begin
              state    <= ARM_ON;
              filt_cnt <= FW'(1);
            end
          end
        end
        ARM_ON: begin
          if (!sync_q) begin
            state    <= IDLE;
            filt_cnt <= '0;
          end else if (rise_now) begin
            state    <= LIVE;
            filt_cnt <= '0;
          end else begin
            filt_cnt <= filt_cnt + FW'(1);
          end
        end
        LIVE: begin
          if (!sync_q) begin
            if (IMMEDIATE) begin
              state <= IDLE;
            end else begin
              state    <= ARM_OFF;
              filt_cnt <= FW'(1);
            end
          end
        end
        ARM_OFF: begin
          if (sync_q) begin
            state    <= LIVE;
            filt_cnt <= '0;
          end else if (fall_now) begin
            state    <= IDLE;
            filt_cnt <= '0;
          end else begin
            filt_cnt <= filt_cnt + FW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          filt_cnt <= '0;
        end
      endcase

      if (rise_now) begin
        live_level  <= 1'b1;
        spill_count <= spill_count + CNT_W'(1);
        dur_cnt     <= DUR_W'(1);
        dur_ovf     <= 1'b0;
      end else if (fall_now) begin
        live_level    <= 1'b0;
        live_duration <= dur_cnt;
        duration_ovf  <= dur_ovf;
      end else if (live_level) begin
        // Dropouts rejected by the filter keep live_level high, so they are timed too.
        if (dur_cnt == '1) begin
          dur_ovf <= 1'b1;
        end else begin
          dur_cnt <= dur_cnt + DUR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_live_edge_conditioner.sv
// tb/tb_live_edge_conditioner.sv - scoreboard bench for live_edge_conditioner
module tb_live_edge_conditioner;

  localparam int CNT_W = 4;
  localparam int DUR_W = 8;
  localparam int LAT   = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             live_in;
  logic             live_level;
  logic             live_rising;
  logic             live_falling;
  logic [CNT_W-1:0] spill_count;
  logic [DUR_W-1:0] live_duration;
  logic             duration_valid;
  logic             duration_ovf;

  live_edge_conditioner #(
    .SYNC_STAGES(2),
    .MIN_WIDTH  (4),
    .CNT_W      (CNT_W),
    .DUR_W      (DUR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .live_in       (live_in),
    .live_level    (live_level),
    .live_rising   (live_rising),
    .live_falling  (live_falling),
    .spill_count   (spill_count),
    .live_duration (live_duration),
    .duration_valid(duration_valid),
    .duration_ovf  (duration_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit fall;
    int cyc;
    int spill;
    int dur;
    bit ovf;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;
  int  total = 0;
  int  bad = 0;
  int  spill_m = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse from the DUT must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && (live_rising || live_falling || duration_valid)) begin
      check("rise_fall_exclusive", live_rising & live_falling, 0);
      if (q.size() == 0) begin
        check("unexpected_event", {live_rising, live_falling, duration_valid}, 0);
      end else begin
        mon_e = q.pop_front();
        check("event_kind", live_falling, mon_e.fall);
        check("event_cycle", cyc, mon_e.cyc);
        if (!mon_e.fall) begin
          check("rise_spill", spill_count, mon_e.spill);
          check("rise_level", live_level, 1);
          check("rise_no_dvalid", duration_valid, 0);
        end else begin
          check("fall_duration", live_duration, mon_e.dur);
          check("fall_ovf", duration_ovf, mon_e.ovf);
          check("fall_dvalid", duration_valid, 1);
          check("fall_level", live_level, 0);
        end
      end
    end
  end

  task automatic push_rise();
    ev_t e;
    spill_m = (spill_m + 1) % 16;
    e.fall = 1'b0; e.cyc = cyc + LAT; e.spill = spill_m; e.dur = 0; e.ovf = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_fall(input int n);
    ev_t e;
    e.fall = 1'b1; e.cyc = cyc + LAT; e.spill = spill_m;
    e.dur = (n > 255) ? 255 : n;
    e.ovf = (n > 255);
    q.push_back(e);
  endtask

  task automatic seg(input bit lvl, input int n);
    live_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic window(input int n, input int gap);
    push_rise();
    seg(1'b1, n);
    push_fall(n);
    seg(1'b0, gap);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, live_level, 0);
    check({tag, "_rising"}, live_rising, 0);
    check({tag, "_falling"}, live_falling, 0);
    check({tag, "_spill"}, spill_count, 0);
    check({tag, "_duration"}, live_duration, 0);
    check({tag, "_dvalid"}, duration_valid, 0);
    check({tag, "_ovf"}, duration_ovf, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    spill_m = 0;
  endtask

  initial begin
    reset = 1'b1;
    live_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    reset = 1'b0;
    @(negedge clk);

    // Clean 100-cycle window.
    window(100, 30);
    check("duration_hold", live_duration, 100);
    check("spill_after_first", spill_count, 1);

    // 3-cycle glitch is rejected, 4 cycles is accepted.
    seg(1'b1, 3);
    seg(1'b0, 20);
    check("glitch_level", live_level, 0);
    check("glitch_spill", spill_count, 1);
    window(4, 20);

    // 200-cycle window with a 2-cycle dropout at cycle 50.
    push_rise();
    seg(1'b1, 50);
    seg(1'b0, 2);
    seg(1'b1, 148);
    push_fall(200);
    seg(1'b0, 30);

    // Duration saturation then recovery.
    window(300, 30);
    window(10, 30);

    // spill_count wraps after 16 rising edges.
    pulse_reset();
    for (int i = 0; i < 17; i++) window(20, 20);
    check("spill_wrap", spill_count, 1);

    // Reset in the middle of a window with live_in held high.
    push_rise();
    seg(1'b1, 30);
    check("pre_reset_level", live_level, 1);
    pulse_reset();
    push_rise();
    seg(1'b1, 40);
    push_fall(40);
    seg(1'b0, 30);
    check("post_reset_spill", spill_count, 1);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
